// File: rtl/int_div_iter_pkg.sv
// -----------------------------------------------------------------------------
// int_div_pkg
// Shared definitions for the iterative integer divider: FSM state encodings,
// the latched operation-mode record, the iteration-count helper and the
// legality helpers used by the elaboration-time parameter checks.
// -----------------------------------------------------------------------------
package int_div_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Legal range of quotient bits retired per iteration
    localparam int RADIX_MIN = 1;
    localparam int RADIX_MAX = 4;

    // Operation mode captured at acceptance
    typedef struct packed {
        logic rv32;
        logic residual;
        logic q_neg;
        logic r_neg;
    } div_mode_t;

    // Number of ITER cycles for an effective width w and radix_bits per step
    function automatic int num_iter(input int w, input int radix_bits);
        return w / radix_bits;
    endfunction

    // Only 1, 2 and 4 quotient bits per cycle are supported
    function automatic bit radix_legal(input int radix_bits);
        return (radix_bits == 1) || (radix_bits == 2) || (radix_bits == 4);
    endfunction

    // Operand width must be a whole number of 32-bit words
    function automatic bit xlen_legal(input int xlen);
        return (xlen >= 32) && ((xlen % 32) == 0);
    endfunction

endpackage

// File: rtl/int_div_iter_if.sv
// -----------------------------------------------------------------------------
// int_div_iter_if
// Request/response bundle between the execute stage and the divider.
//   i_ena       start request (ignored while o_busy=1)
//   i_unsigned  1 = DIVU/REMU, 0 = signed
//   i_rv32      word mode, operands taken from bits [31:0]
//   i_residual  1 = remainder, 0 = quotient
//   i_a1, i_a2  dividend, divisor
//   o_res       result, held until the next result
//   o_valid     one-cycle result strobe
//   o_busy      operation in flight
// master: requester side, slave: divider side.
// -----------------------------------------------------------------------------
interface int_div_iter_if #(
    parameter int XLEN = 64
);
    logic            i_ena;
    logic            i_unsigned;
    logic            i_rv32;
    logic            i_residual;
    logic [XLEN-1:0] i_a1;
    logic [XLEN-1:0] i_a2;
    logic [XLEN-1:0] o_res;
    logic            o_valid;
    logic            o_busy;

    modport master (
        output i_ena, i_unsigned, i_rv32, i_residual, i_a1, i_a2,
        input  o_res, o_valid, o_busy
    );

    modport slave (
        input  i_ena, i_unsigned, i_rv32, i_residual, i_a1, i_a2,
        output o_res, o_valid, o_busy
    );
endinterface

// File: rtl/int_div_iter_stage.sv
// -----------------------------------------------------------------------------
// int_div_stage
// Combinational single iteration of a restoring divider retiring RADIX_BITS
// quotient bits. The partial remainder is shifted left by RADIX_BITS, the next
// dividend bits are appended, and the largest multiple k*divisor (k in
// 1..2^RADIX_BITS-1) not exceeding it is subtracted.
//   part_rem  in   WIDTH+RADIX_BITS  current partial remainder (< divisor)
//   divisor   in   WIDTH             divisor magnitude
//   dvd_bits  in   RADIX_BITS        next dividend bits, MSB first
//   next_rem  out  WIDTH+RADIX_BITS  updated partial remainder
//   q_bits    out  RADIX_BITS        quotient digit for this step
// -----------------------------------------------------------------------------
module int_div_stage #(
    parameter int WIDTH      = 64,
    parameter int RADIX_BITS = 2
) (
    input  logic [WIDTH+RADIX_BITS-1:0] part_rem,
    input  logic [WIDTH-1:0]            divisor,
    input  logic [RADIX_BITS-1:0]       dvd_bits,
    output logic [WIDTH+RADIX_BITS-1:0] next_rem,
    output logic [RADIX_BITS-1:0]       q_bits
);
    localparam int PW = WIDTH + RADIX_BITS;

    logic [PW-1:0] shifted_s;
    logic [PW-1:0] mult_s;
    logic          hit_s;

    // Trial subtraction against every divisor multiple; multiples increase
    // with k, so the last one that fits is the quotient digit
    always_comb begin
        // part_rem < divisor, so the bits shifted out are always zero
        shifted_s = (part_rem << RADIX_BITS) | PW'(dvd_bits);
        next_rem  = shifted_s;
        q_bits    = {RADIX_BITS{1'b0}};
        mult_s    = {PW{1'b0}};
        hit_s     = 1'b0;
        for (int k = 1; k < (2 ** RADIX_BITS); k++) begin
            mult_s   = PW'(divisor) * PW'(k);
            hit_s    = (mult_s <= shifted_s);
            next_rem = hit_s ? (shifted_s - mult_s) : next_rem;
            q_bits   = hit_s ? RADIX_BITS'(k) : q_bits;
        end
    end
endmodule

// File: rtl/int_div_iter.sv
// -----------------------------------------------------------------------------
// int_div_iter
// Iterative integer divider for the River integer pipeline. Supports signed
// and unsigned operands, RV32 word mode, quotient/remainder selection and
// RISC-V divide-by-zero / signed-overflow results (both skip the iteration).
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   bus     int_div_iter_if.slave request/response bundle
// Latency from acceptance: W/RADIX_BITS + 2 cycles, or 2 for special cases.
// -----------------------------------------------------------------------------
module int_div_iter
    import int_div_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    int_div_iter_if.slave bus
);
    localparam int CNT_W  = $clog2(XLEN + 1);
    localparam int N_FULL = num_iter(XLEN, RADIX_BITS);
    localparam int N_WORD = num_iter(32, RADIX_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_FULL - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(N_WORD - 1);
    localparam int PW = XLEN + RADIX_BITS;

    generate
        if (!xlen_legal(XLEN)) begin : g_bad_xlen
            $error("int_div_iter: XLEN must be a multiple of 32");
        end
        if (!radix_legal(RADIX_BITS)) begin : g_bad_radix
            $error("int_div_iter: RADIX_BITS must be 1, 2 or 4");
        end
    endgenerate

    // Extend a 32-bit value to XLEN, sign-extending when sgn is set
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31] & sgn}};
        r[31:0] = v;
        return r;
    endfunction

    // Two's-complement negation
    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Registers
    logic [1:0]       state_r;
    div_mode_t        mode_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PW-1:0]    rem_r;
    logic [XLEN-1:0]  q_r;
    logic [XLEN-1:0]  dvd_r;
    logic [XLEN-1:0]  dsr_r;
    logic [XLEN-1:0]  o_res_r;
    logic             o_valid_r;
    logic             o_busy_r;

    // Combinational
    logic [XLEN-1:0]       a1_ext_s;
    logic [XLEN-1:0]       a2_ext_s;
    logic [XLEN-1:0]       abs1_s;
    logic [XLEN-1:0]       abs2_s;
    logic [XLEN-1:0]       dvd_init_s;
    logic [XLEN-1:0]       min_w_s;
    logic                  neg1_s;
    logic                  neg2_s;
    logic                  dz_s;
    logic                  ovf_s;
    logic [PW-1:0]         stage_rem_s;
    logic [RADIX_BITS-1:0] stage_q_s;
    logic [XLEN-1:0]       q_fix_s;
    logic [XLEN-1:0]       r_fix_s;
    logic [XLEN-1:0]       sel_s;
    logic [XLEN-1:0]       fix_s;

    // Operand preparation on the raw request: width adjust, magnitudes,
    // result signs and special-case detection
    always_comb begin
        if (bus.i_rv32) begin
            a1_ext_s = ext32(bus.i_a1[31:0], ~bus.i_unsigned);
            a2_ext_s = ext32(bus.i_a2[31:0], ~bus.i_unsigned);
            min_w_s  = ext32(32'h8000_0000, 1'b1);
        end else begin
            a1_ext_s = bus.i_a1;
            a2_ext_s = bus.i_a2;
            min_w_s  = XLEN'(1) << (XLEN - 1);
        end
        // After extension bit XLEN-1 carries the sign for either width
        neg1_s = ~bus.i_unsigned & a1_ext_s[XLEN-1];
        neg2_s = ~bus.i_unsigned & a2_ext_s[XLEN-1];
        abs1_s = neg1_s ? twos_neg(a1_ext_s) : a1_ext_s;
        abs2_s = neg2_s ? twos_neg(a2_ext_s) : a2_ext_s;
        // Word-mode dividends are left-aligned so the MSB-first shift works
        // identically and only 32/RADIX_BITS steps are needed
        dvd_init_s = bus.i_rv32 ? (abs1_s << (XLEN - 32)) : abs1_s;
        dz_s  = (a2_ext_s == {XLEN{1'b0}});
        ovf_s = ~bus.i_unsigned & (a1_ext_s == min_w_s) & (a2_ext_s == {XLEN{1'b1}});
    end

    int_div_stage #(
        .WIDTH      (XLEN),
        .RADIX_BITS (RADIX_BITS)
    ) u_stage (
        .part_rem (rem_r),
        .divisor  (dsr_r),
        .dvd_bits (dvd_r[XLEN-1 -: RADIX_BITS]),
        .next_rem (stage_rem_s),
        .q_bits   (stage_q_s)
    );

    // Final sign fix-up, quotient/remainder select and word-mode extension
    always_comb begin
        q_fix_s = mode_r.q_neg ? twos_neg(q_r) : q_r;
        r_fix_s = mode_r.r_neg ? twos_neg(rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];
        sel_s   = mode_r.residual ? r_fix_s : q_fix_s;
        if (mode_r.rv32) begin
            fix_s = ext32(sel_s[31:0], 1'b1);
        end else begin
            fix_s = sel_s;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            mode_r    <= '0;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {PW{1'b0}};
            q_r       <= {XLEN{1'b0}};
            dvd_r     <= {XLEN{1'b0}};
            dsr_r     <= {XLEN{1'b0}};
            o_res_r   <= {XLEN{1'b0}};
            o_valid_r <= 1'b0;
            o_busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_valid_r <= 1'b0;
                    if (bus.i_ena) begin
                        o_busy_r        <= 1'b1;
                        mode_r.rv32     <= bus.i_rv32;
                        mode_r.residual <= bus.i_residual;
                        dvd_r           <= {XLEN{1'b0}};
                        dsr_r           <= {XLEN{1'b0}};
                        cnt_r           <= {CNT_W{1'b0}};
                        if (dz_s) begin
                            // Final values loaded directly; no sign fix-up
                            q_r          <= {XLEN{1'b1}};
                            rem_r        <= PW'(a1_ext_s);
                            mode_r.q_neg <= 1'b0;
                            mode_r.r_neg <= 1'b0;
                            state_r      <= ST_FIX;
                        end else if (ovf_s) begin
                            q_r          <= a1_ext_s;
                            rem_r        <= {PW{1'b0}};
                            mode_r.q_neg <= 1'b0;
                            mode_r.r_neg <= 1'b0;
                            state_r      <= ST_FIX;
                        end else begin
                            q_r          <= {XLEN{1'b0}};
                            rem_r        <= {PW{1'b0}};
                            dvd_r        <= dvd_init_s;
                            dsr_r        <= abs2_s;
                            mode_r.q_neg <= neg1_s ^ neg2_s;
                            mode_r.r_neg <= neg1_s;
                            cnt_r        <= bus.i_rv32 ? CNT_WORD : CNT_FULL;
                            state_r      <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    rem_r <= stage_rem_s;
                    q_r   <= {q_r[XLEN-RADIX_BITS-1:0], stage_q_s};
                    dvd_r <= dvd_r << RADIX_BITS;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    o_res_r   <= fix_s;
                    o_valid_r <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    o_valid_r <= 1'b0;
                    o_busy_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    o_valid_r <= 1'b0;
                    o_busy_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_res   = o_res_r;
    assign bus.o_valid = o_valid_r;
    assign bus.o_busy  = o_busy_r;
endmodule

// File: doc/int_div_iter.md
Name: int_div_iter

Overview:
- Parametrised iterative integer divider for the River integer pipeline; the next generation of the fixed 64-bit divide stage.
- Generalises operand width and quotient bits retired per cycle.
- Adds RV32 word mode, signed/unsigned modes, quotient or remainder selection, and RISC-V divide-by-zero and overflow semantics with early exit.
- Sits behind the execute stage's multi-cycle arithmetic select; one operation in flight.

Parameters:
- XLEN, 64: operand and result width; must be a multiple of 32.
- RADIX_BITS, 2: quotient bits produced per iteration; legal values 1, 2, 4.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_ena  in  1  start request; sampled only when o_busy=0.
- i_unsigned  in  1  1 selects unsigned operands (DIVU/REMU); 0 selects signed.
- i_rv32  in  1  word mode: use a[31:0] only; result is sign-extended from bit 31.
- i_residual  in  1  1 returns remainder; 0 returns quotient.
- i_a1  in  XLEN  dividend.
- i_a2  in  XLEN  divisor.
- o_res  out  XLEN  result; valid only while o_valid=1, held until the next result.
- o_valid  out  1  one-cycle result strobe.
- o_busy  out  1  operation in flight; high from the cycle after acceptance through the o_valid cycle.

Behaviour:
- Reset values: o_res=0, o_valid=0, o_busy=0, state=IDLE. All internal registers are cleared.
- Reset mid-operation: the next edge returns to IDLE and the in-flight operation is discarded; o_valid is never raised for it.
- Acceptance: i_ena=1 while in IDLE (cycle 0). Operands and mode bits are latched at that edge. i_ena while o_busy=1 is ignored.
- Operand prep at acceptance:
  - rv32: operands are sign- or zero-extended from bit 31 (per i_unsigned). Effective width W=32; otherwise W=XLEN.
  - Signed mode: absolute values are taken. q_neg = sign(a1) xor sign(a2); r_neg = sign(a1).
- States:
  - IDLE.
  - ITER: N = W/RADIX_BITS cycles. Each cycle shifts RADIX_BITS dividend bits into the partial remainder and performs restoring comparison against divisor multiples 1..2^RADIX_BITS-1. This yields RADIX_BITS quotient bits, MSB first.
  - FIX: one cycle. Applies two's-complement negation per q_neg/r_neg, selects quotient or remainder, and applies rv32 sign-extension.
  - DONE: o_valid=1 for one cycle, then IDLE.
- Special cases, detected at acceptance; they skip ITER and go straight to FIX:
  - Divide by zero: quotient = all ones, remainder = dividend (both width-adjusted for rv32).
  - Signed overflow (a1 = most-negative of width W, a2 = -1): quotient = a1, remainder = 0.
- Latency:
  - Normal: o_valid in cycle N+2 (XLEN=64, RADIX_BITS=2: 34 for 64-bit, 18 for rv32).
  - Special: o_valid in cycle 2.
- Throughput: a new i_ena is accepted in the cycle after DONE.
- Arithmetic: the partial remainder is W+RADIX_BITS bits wide, so no overflow is possible during trial subtraction. Quotient and remainder are computed on the full W bits. No X propagation from unused upper bits in rv32.

Decomposition:
- Package int_div_pkg:
  - state enum (IDLE, ITER, FIX, DONE);
  - function returning N for (W, RADIX_BITS);
  - legality assertion constants for RADIX_BITS.
- One sub-module, int_div_stage: combinational one-iteration step. Parametrised WIDTH and RADIX_BITS. Inputs are partial remainder, divisor and next dividend bits; outputs are next partial remainder and RADIX_BITS quotient bits. The top instantiates it once and registers its outputs each ITER cycle.
- Elaboration-time checks: XLEN%32==0 and RADIX_BITS in {1,2,4}.

Test Plan:
- XLEN=64, RADIX_BITS=2, unsigned. 100/7, quotient: o_res=14 with o_valid in cycle 34. Same operands with i_residual=1: o_res=2.
- Signed -7/2: quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF. Repeat with RADIX_BITS=1 (valid cycle 66) and RADIX_BITS=4 (valid cycle 18); results must be identical.
- Divide by zero, 5/0 signed: quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, o_valid in cycle 2. Signed overflow 0x8000_0000_0000_0000 / -1: quotient 0x8000_0000_0000_0000, remainder 0, cycle 2.
- rv32:
  - DIVUW 0x1234_5678_FFFF_FFFF / 2: o_res=0x0000_0000_7FFF_FFFF in cycle 18.
  - DIVW a1=0x8000_0000, a2=0xFFFF_FFFF: o_res=0xFFFF_FFFF_8000_0000 in cycle 2.
  - REMW -9/4: o_res=0xFFFF_FFFF_FFFF_FFFF.
- Handshake and reset:
  - i_ena pulsed again in cycle 5 of a running 100/7: ignored, single o_valid with 14.
  - i_rst=1 in cycle 10 of a running divide: o_busy=0 and o_valid=0 from cycle 11, no strobe afterwards.
  - i_ena in cycle 12 after that reset: accepted normally.
- Back-to-back: second i_ena in the cycle after o_valid is accepted, and its result arrives after the full latency. Random signed/unsigned/rv32 sweep (10k ops, all RADIX_BITS) matches the reference model bit-exactly.
